intr_ctrl: RTL and testbench
============================

// Module: intr_ctrl
// PURPOSE
//  Interrupt controller on the source side of the CPU exception path.
//  Collects external IRQ lines, latches rising edges as pending, applies a
//  CPU-programmed mask and fixed priority, and raises one request at a time.
//  Handshake: IntReq -> IntAck (CPU saves EPC, enters handler) -> Eret (CPU returns).
//  Supplies a Cause-format word for the CPU Cause register.
// PARAMETERS
//  NIRQ   8   number of IRQ inputs; legal range 1..8
//  IDW    3   width of IntId; must be >= clog2(NIRQ), min 1
// PORTS
//  Clk       in   1     system clock; all state updates on rising edge
//  Rst       in   1     reset: synchronous, active-high
//  Irq       in   NIRQ  external interrupt lines, edge-sensitive, synchronous to Clk
//  Ie        in   1     global interrupt enable (CPU Status IE bit)
//  Wen       in   1     CPU register write strobe
//  Addr      in   2     register select for read and write
//  Wdata     in   32    CPU write data
//  Rdata     out  32    register read data, combinational from Addr
//  IntReq    out  1     interrupt request to CPU
//  IntId     out  IDW   id of requested/in-service line
//  IntAck    in   1     CPU accepts request; 1-cycle pulse
//  Eret      in   1     CPU returns from handler; 1-cycle pulse
//  IntCause  out  32    {16'b0, IP[7:0], 1'b0, ExcCode=5'd0, 2'b0}
//                       IP = pending & mask, zero-extended to 8 bits
//  Busy      out  1     1 while in SERVICE
// BEHAVIOUR
//  Reset (Rst=1 at an edge): state=IDLE, mask=0, pending=0, IntReq=0, IntId=0,
//   Busy=0, insvc=0. irq_q loads Irq, so lines already high are not edges.
//  Edge detect: rise[i] = Irq[i] & ~irq_q[i]; irq_q <= Irq every edge.
//  pending[i] <= 1 on rise[i], regardless of mask or state.
//  Register map:
//   0 MASK     RW  bits[NIRQ-1:0]; upper bits read 0
//   1 PENDING  R; writing 1 clears the bit (W1C)
//   2 STATUS   R   {27'b0, state[1:0], Busy, IntReq, Ie}
//   3 INSVC    R   {zero, insvc id}
//  Writes to addr 2 and 3 are ignored.
//  Set vs clear in the same cycle (ack clear, or W1C): set wins, bit stays 1.
//  active = pending & mask. sel = lowest index set in active (index 0 = highest priority).
//  FSM:
//   IDLE: IntReq=0. If Ie & |active: latch IntId=sel, go REQ.
//   REQ: IntReq=1, IntId held stable.
//    - IntAck: clear pending[IntId], insvc=IntId, go SERVICE.
//    - Ie=0 or ~active[IntId] (masked/cleared) without IntAck: go IDLE and
//      withdraw IntReq. A higher-priority arrival does not preempt.
//   SERVICE: IntReq=0, Busy=1. No nesting.
//    - Eret: go IDLE.
//    - Re-arbitrate no earlier than the cycle after Eret.
//  IntAck outside REQ and Eret outside SERVICE are ignored.
//  IntAck and Eret together: treated as IntAck only.
//  Latency: rise sampled at edge k -> pending=1 after k -> IntReq=1 after k+1.
//  Reset mid-operation (REQ or SERVICE): immediate return to IDLE, all state cleared.
// TESTING
//  1 Reset, mask=0xFF, Ie=1, pulse Irq[3] at edge k -> IntReq=1 after k+1,
//    IntId=3, IntCause=0x0000_0800.
//  2 Irq[5] and Irq[2] rise together -> IntId=2. Ack -> pending=0x20, Busy=1.
//    Eret -> IntId=5 two edges later.
//  3 mask=0xFE, Irq[0] rises -> no IntReq, PENDING=0x01. Write mask=0xFF
//    -> IntReq after next edge.
//  4 In REQ drop Ie -> IntReq=0 next edge, pending kept. Raise Ie -> re-request same id.
//  5 Irq[1] re-rises in the same cycle as IntAck for id 1 -> pending[1] stays 1.
//    W1C addr1=0x02 -> bit clears.
//  6 Rst asserted in SERVICE -> all outputs reset next edge.
//    Irq held high through reset -> no request.

Source files
------------

// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge IRQ capture, CPU mask, fixed priority
// (index 0 highest), one request at a time with an IntAck/Eret handshake.
module intr_ctrl #(
    parameter int NIRQ = 8,
    parameter int IDW  = 3
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [NIRQ-1:0] Irq,
    input  logic            Ie,
    input  logic            Wen,
    input  logic [1:0]      Addr,
    input  logic [31:0]     Wdata,
    output logic [31:0]     Rdata,
    output logic            IntReq,
    output logic [IDW-1:0]  IntId,
    input  logic            IntAck,
    input  logic            Eret,
    output logic [31:0]     IntCause,
    output logic            Busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_e;

    state_e          state_q;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] mask_q,  mask_d;
    logic [NIRQ-1:0] pend_q,  pend_d;
    logic [IDW-1:0]  insvc_q;
    logic [IDW-1:0]  int_id_q;
    logic            int_req_q;
    logic            busy_q;

    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] active;
    logic [NIRQ-1:0] id_onehot;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] w1c;
    logic [IDW-1:0]  sel;
    logic            ack_take;
    logic            id_active;
    logic [7:0]      ip;
    logic            unused_wdata;

    assign unused_wdata = ^Wdata[31:NIRQ];

    assign rise      = Irq & ~irq_q;
    assign active    = pend_q & mask_q;
    assign id_onehot = NIRQ'(1) << int_id_q;
    assign id_active = |(active & id_onehot);
    assign ack_take  = (state_q == S_REQ) && IntAck;
    assign ack_clr   = ack_take ? id_onehot : '0;
    assign w1c       = (Wen && Addr == 2'd1) ? Wdata[NIRQ-1:0] : '0;

    // OR-ing rise in after the clear makes a same-cycle set win over any clear.
    assign pend_d = (pend_q & ~(ack_clr | w1c)) | rise;
    assign mask_d = (Wen && Addr == 2'd0) ? Wdata[NIRQ-1:0] : mask_q;

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) sel = IDW'(i);
        end
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block.
    always_ff @(posedge Clk) begin
        irq_q <= Irq;
        if (Rst) begin
            mask_q <= '0;
            pend_q <= '0;
        end else begin
            mask_q <= mask_d;
            pend_q <= pend_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            int_req_q <= 1'b0;
            int_id_q  <= '0;
            busy_q    <= 1'b0;
            insvc_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Ie && |active) begin
                        int_id_q  <= sel;
                        int_req_q <= 1'b1;
                        state_q   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (IntAck) begin
                        insvc_q   <= int_id_q;
                        int_req_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_SERVICE;
                    end else if (!Ie || !id_active) begin
                        int_req_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                S_SERVICE: begin
                    // An IntAck in the same cycle masks the Eret.
                    if (Eret && !IntAck) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    int_req_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        Rdata = '0;
        case (Addr)
            2'd0:    Rdata[NIRQ-1:0] = mask_q;
            2'd1:    Rdata[NIRQ-1:0] = pend_q;
            2'd2:    Rdata[4:0]      = {state_q, busy_q, int_req_q, Ie};
            default: Rdata[IDW-1:0]  = insvc_q;
        endcase
    end

    always_comb begin
        ip           = '0;
        ip[NIRQ-1:0] = active;
    end

    assign IntCause = {16'b0, ip, 1'b0, 5'd0, 2'b0};
    assign IntReq   = int_req_q;
    assign IntId    = int_id_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed handshake scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_intr_ctrl;

    localparam int NIRQ = 8;
    localparam int IDW  = 3;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  Irq = '0;
    logic        Ie = 1'b0;
    logic        Wen = 1'b0;
    logic [1:0]  Addr = '0;
    logic [31:0] Wdata = '0;
    logic [31:0] Rdata;
    logic        IntReq;
    logic [2:0]  IntId;
    logic        IntAck = 1'b0;
    logic        Eret = 1'b0;
    logic [31:0] IntCause;
    logic        Busy;

    always #5 Clk = ~Clk;

    intr_ctrl #(.NIRQ(NIRQ), .IDW(IDW)) dut (
        .Clk(Clk), .Rst(Rst), .Irq(Irq), .Ie(Ie), .Wen(Wen), .Addr(Addr),
        .Wdata(Wdata), .Rdata(Rdata), .IntReq(IntReq), .IntId(IntId),
        .IntAck(IntAck), .Eret(Eret), .IntCause(IntCause), .Busy(Busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 = waiting, 1 = requesting, 2 = in handler.
    logic [7:0] m_prev = '0;
    logic [7:0] m_pend = '0;
    logic [7:0] m_mask = '0;
    int         m_phase = 0;
    int         m_id = 0;
    int         m_insvc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int highest_prio(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step;
        logic [7:0] live;
        logic [7:0] cleared;
        if (Rst) begin
            m_phase = 0; m_mask = '0; m_pend = '0; m_id = 0; m_insvc = 0;
            m_prev  = Irq;
            return;
        end
        live    = m_pend & m_mask;
        cleared = '0;
        if (m_phase == 0) begin
            if (Ie && live != 0) begin
                m_id    = highest_prio(live);
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (IntAck) begin
                cleared[m_id] = 1'b1;
                m_insvc = m_id;
                m_phase = 2;
            end else if (!Ie || !live[m_id]) begin
                m_phase = 0;
            end
        end else if (Eret && !IntAck) begin
            m_phase = 0;
        end
        if (Wen && Addr == 2'd0) m_mask = Wdata[7:0];
        if (Wen && Addr == 2'd1) cleared = cleared | Wdata[7:0];
        m_pend = (m_pend & ~cleared) | (Irq & ~m_prev);
        m_prev = Irq;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {24'b0, m_mask};
            2'd1:    return {24'b0, m_pend};
            2'd2:    return {27'b0, 2'(m_phase), m_phase == 2, m_phase == 1, Ie};
            default: return 32'(m_insvc);
        endcase
    endfunction

    task automatic compare_all;
        check("IntReq", 32'(IntReq), 32'(m_phase == 1));
        check("IntId", 32'(IntId), 32'(m_id));
        check("Busy", 32'(Busy), 32'(m_phase == 2));
        check("IntCause", IntCause, {16'b0, m_pend & m_mask, 8'b0});
        check("Rdata", Rdata, model_read(Addr));
    endtask

    task automatic cycle;
        model_step();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    initial begin
        // Reset with quiet inputs.
        cycle(); cycle();
        Rst = 1'b0;
        cycle();
        check("reset_intreq", 32'(IntReq), 32'd0);

        // Scenario 1: single source, latency and Cause word.
        Wen = 1'b1; Addr = 2'd0; Wdata = 32'hFF; cycle();
        Wen = 1'b0; Ie = 1'b1;
        Irq = 8'h08; cycle();
        check("s1_no_req_yet", 32'(IntReq), 32'd0);
        Irq = 8'h00; cycle();
        check("s1_req", 32'(IntReq), 32'd1);
        check("s1_id", 32'(IntId), 32'd3);
        check("s1_cause", IntCause, 32'h0000_0800);
        IntAck = 1'b1; cycle(); IntAck = 1'b0;
        Eret = 1'b1; cycle(); Eret = 1'b0;
        cycle();

        // Scenario 2: simultaneous sources, priority and post-Eret re-arbitration.
        Irq = 8'h24; cycle();
        Irq = 8'h00; cycle();
        check("s2_id_first", 32'(IntId), 32'd2);
        Addr = 2'd1; IntAck = 1'b1; cycle(); IntAck = 1'b0;
        check("s2_pending", Rdata, 32'h20);
        check("s2_busy", 32'(Busy), 32'd1);
        Eret = 1'b1; cycle(); Eret = 1'b0;
        cycle();
        check("s2_id_second", 32'(IntId), 32'd5);
        IntAck = 1'b1; cycle(); IntAck = 1'b0;
        Eret = 1'b1; cycle(); Eret = 1'b0;

        // Scenario 5: re-rise during ack keeps pending, then W1C clears it.
        Irq = 8'h02; cycle();
        Irq = 8'h00; cycle();
        Irq = 8'h02; IntAck = 1'b1; cycle(); IntAck = 1'b0; Irq = 8'h00;
        check("s5_set_wins", Rdata, 32'h02);
        Wen = 1'b1; Wdata = 32'h02; cycle(); Wen = 1'b0;
        check("s5_w1c", Rdata, 32'h00);
        Eret = 1'b1; cycle(); Eret = 1'b0;

        // Scenario 6: reset while in service with a line held high.
        Irq = 8'h01; cycle(); cycle();
        IntAck = 1'b1; cycle(); IntAck = 1'b0;
        Irq = 8'h81; Rst = 1'b1; cycle(); Rst = 1'b0;
        check("s6_busy_cleared", 32'(Busy), 32'd0);
        Wen = 1'b1; Addr = 2'd0; Wdata = 32'hFF; cycle(); Wen = 1'b0;
        Addr = 2'd1; cycle(); cycle();
        check("s6_no_request", 32'(IntReq), 32'd0);
        check("s6_no_pending", Rdata, 32'h00);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            Rst    = ($urandom_range(199) == 0);
            Irq    = Irq ^ 8'($urandom & $urandom & $urandom);
            Ie     = ($urandom_range(9) != 0);
            Wen    = ($urandom_range(9) == 0);
            Addr   = 2'($urandom);
            Wdata  = ($urandom_range(1) == 0) ? 32'hFF : $urandom;
            IntAck = (m_phase == 1) ? ($urandom_range(1) == 0) : ($urandom_range(31) == 0);
            Eret   = (m_phase == 2) ? ($urandom_range(4) == 0) : ($urandom_range(31) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
